decode: RTL and testbench

- Instruction-decode stage of the ARM pipeline. It sits between fetch (upstream) and execute (downstream).
- It accepts one 32-bit ARM instruction per trigger handshake and classifies it into a 4-bit type.
- It fetches the needed source registers from the register bank over a request/ready port guarded by a semaphore.
- It presents up to four 32-bit operands downstream with a one-cycle trigger pulse.

---
 rtl/decode.sv | 210 +++++++++++++++++++++
 tb/tb_decode.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// ARM instruction-decode stage: classifies one instruction, fetches its source
// registers from the register bank, then hands the operands to execute.
module decode (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dataIn,
   input  logic        triggerIn,
   output logic        readyOut,
   output logic [31:0] dataOut1,
   output logic [31:0] dataOut2,
   output logic [31:0] dataOut3,
   output logic [31:0] dataOut4,
   output logic [3:0]  typeOut,
   output logic        triggerOut,
   input  logic        readyIn,
   input  logic        readyInRB,
   input  logic [31:0] dataInRB,
   input  logic        semRB,
   output logic        rwRB,
   output logic [3:0]  addrRB,
   output logic        triggerOutRB
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StEmit} state_e;

   state_e          state_q;
   logic [31:0]     instr_q, op2_q, op3_q, op4_q;
   logic [3:0]      type_q;
   logic [2:0][3:0] rd_addr_q;
   logic [2:0][1:0] rd_tgt_q;
   logic [1:0]      rd_cnt_q, rd_idx_q;
   logic            ready_q, trig_out_q, trig_rb_q;
   logic [3:0]      addr_rb_q;
   logic [31:0]     out1_q, out2_q, out3_q, out4_q;
   logic [3:0]      out_type_q;

   logic [3:0]      dec_type;
   logic [31:0]     dec_op2, dec_op3, dec_op4;
   logic [2:0]      need;
   logic [3:0]      a2, a3, a4;
   logic [31:0]     imm32, imm_rot;
   logic [4:0]      rot_sh;
   logic [2:0][3:0] dec_rd_addr;
   logic [2:0][1:0] dec_rd_tgt;
   logic [1:0]      dec_rd_cnt;

   assign imm32   = {24'h0, dataIn[7:0]};
   assign rot_sh  = {dataIn[11:8], 1'b0};
   assign imm_rot = (imm32 >> rot_sh) | (imm32 << (6'd32 - {1'b0, rot_sh}));

   // need[0..2] flags a register read for operand A, B, C respectively
   always_comb begin
      dec_type = 4'hF;
      dec_op2  = '0;
      dec_op3  = '0;
      dec_op4  = '0;
      need     = 3'b000;
      a2       = dataIn[19:16];
      a3       = dataIn[3:0];
      a4       = dataIn[11:8];
      if (dataIn[27:4] == 24'h12FFF1) begin
         dec_type = 4'd3;
         need     = 3'b001;
         a2       = dataIn[3:0];
      end else if (dataIn[27:22] == 6'd0 && dataIn[7:4] == 4'b1001) begin
         dec_type = 4'd2;
         need     = {dataIn[21], 2'b11};
         a2       = dataIn[3:0];
         a3       = dataIn[11:8];
         a4       = dataIn[15:12];
      end else if (dataIn[27:25] == 3'b000) begin
         dec_type = 4'd0;
         need     = {dataIn[4], 2'b11};
      end else if (dataIn[27:25] == 3'b001) begin
         dec_type = 4'd1;
         need     = 3'b001;
         dec_op3  = imm_rot;
      end else if (dataIn[27:26] == 2'b01) begin
         dec_type = 4'd4;
         need     = {~dataIn[20], dataIn[25], 1'b1};
         a4       = dataIn[15:12];
         dec_op3  = dataIn[25] ? 32'h0 : {20'h0, dataIn[11:0]};
      end else if (dataIn[27:25] == 3'b100) begin
         dec_type = 4'd5;
         need     = 3'b001;
         dec_op3  = {16'h0, dataIn[15:0]};
      end else if (dataIn[27:25] == 3'b101) begin
         dec_type = 4'd6;
         dec_op2  = {{6{dataIn[23]}}, dataIn[23:0], 2'b00};
         dec_op3  = {31'h0, dataIn[24]};
      end else if (dataIn[27:24] == 4'hF) begin
         dec_type = 4'd7;
         dec_op2  = {8'h0, dataIn[23:0]};
      end
   end

   always_comb begin
      dec_rd_addr = '0;
      dec_rd_tgt  = '0;
      dec_rd_cnt  = 2'd0;
      if (need[0]) begin
         dec_rd_addr[dec_rd_cnt] = a2;
         dec_rd_tgt[dec_rd_cnt]  = 2'd0;
         dec_rd_cnt              = dec_rd_cnt + 2'd1;
      end
      if (need[1]) begin
         dec_rd_addr[dec_rd_cnt] = a3;
         dec_rd_tgt[dec_rd_cnt]  = 2'd1;
         dec_rd_cnt              = dec_rd_cnt + 2'd1;
      end
      if (need[2]) begin
         dec_rd_addr[dec_rd_cnt] = a4;
         dec_rd_tgt[dec_rd_cnt]  = 2'd2;
         dec_rd_cnt              = dec_rd_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         instr_q    <= '0;
         op2_q      <= '0;
         op3_q      <= '0;
         op4_q      <= '0;
         type_q     <= '0;
         rd_addr_q  <= '0;
         rd_tgt_q   <= '0;
         rd_cnt_q   <= '0;
         rd_idx_q   <= '0;
         ready_q    <= 1'b0;
         trig_out_q <= 1'b0;
         trig_rb_q  <= 1'b0;
         addr_rb_q  <= '0;
         out1_q     <= '0;
         out2_q     <= '0;
         out3_q     <= '0;
         out4_q     <= '0;
         out_type_q <= '0;
      end else begin
         trig_out_q <= 1'b0;
         trig_rb_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (triggerIn) begin
                  instr_q   <= dataIn;
                  type_q    <= dec_type;
                  op2_q     <= dec_op2;
                  op3_q     <= dec_op3;
                  op4_q     <= dec_op4;
                  rd_addr_q <= dec_rd_addr;
                  rd_tgt_q  <= dec_rd_tgt;
                  rd_cnt_q  <= dec_rd_cnt;
                  rd_idx_q  <= 2'd0;
                  ready_q   <= 1'b0;
                  state_q   <= (dec_rd_cnt == 2'd0) ? StEmit : StReq;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            StReq: begin
               if (!semRB) begin
                  trig_rb_q <= 1'b1;
                  addr_rb_q <= rd_addr_q[rd_idx_q];
                  state_q   <= StWait;
               end
            end
            StWait: begin
               if (readyInRB) begin
                  case (rd_tgt_q[rd_idx_q])
                     2'd0:    op2_q <= dataInRB;
                     2'd1:    op3_q <= dataInRB;
                     default: op4_q <= dataInRB;
                  endcase
                  if (rd_idx_q == rd_cnt_q - 2'd1) begin
                     state_q <= StEmit;
                  end else begin
                     rd_idx_q <= rd_idx_q + 2'd1;
                     state_q  <= StReq;
                  end
               end
            end
            StEmit: begin
               if (readyIn) begin
                  out1_q     <= instr_q;
                  out2_q     <= op2_q;
                  out3_q     <= op3_q;
                  out4_q     <= op4_q;
                  out_type_q <= type_q;
                  trig_out_q <= 1'b1;
                  ready_q    <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign readyOut     = ready_q;
   assign dataOut1     = out1_q;
   assign dataOut2     = out2_q;
   assign dataOut3     = out3_q;
   assign dataOut4     = out4_q;
   assign typeOut      = out_type_q;
   assign triggerOut   = trig_out_q;
   assign rwRB         = 1'b0;
   assign addrRB       = addr_rb_q;
   assign triggerOutRB = trig_rb_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: one instruction of each major class,
// register-bank semaphore stall, execute back-pressure and reset abort.
module tb_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dataIn;
   logic        triggerIn;
   logic        readyOut;
   logic [31:0] dataOut1, dataOut2, dataOut3, dataOut4;
   logic [3:0]  typeOut;
   logic        triggerOut;
   logic        readyIn;
   logic        readyInRB;
   logic [31:0] dataInRB;
   logic        semRB;
   logic        rwRB;
   logic [3:0]  addrRB;
   logic        triggerOutRB;

   int checks = 0;
   int errors = 0;
   int rb_pulses = 0;
   int base;

   decode dut (
      .clk          (clk),
      .rst          (rst),
      .dataIn       (dataIn),
      .triggerIn    (triggerIn),
      .readyOut     (readyOut),
      .dataOut1     (dataOut1),
      .dataOut2     (dataOut2),
      .dataOut3     (dataOut3),
      .dataOut4     (dataOut4),
      .typeOut      (typeOut),
      .triggerOut   (triggerOut),
      .readyIn      (readyIn),
      .readyInRB    (readyInRB),
      .dataInRB     (dataInRB),
      .semRB        (semRB),
      .rwRB         (rwRB),
      .addrRB       (addrRB),
      .triggerOutRB (triggerOutRB)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (triggerOutRB === 1'b1) rb_pulses <= rb_pulses + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] instr, input string tag);
      int n = 0;
      while (readyOut !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, {31'h0, readyOut}, 32'd1);
      dataIn    = instr;
      triggerIn = 1'b1;
      @(negedge clk);
      triggerIn = 1'b0;
      chk({tag, "_busy"}, {31'h0, readyOut}, 32'd0);
   endtask

   task automatic serve(input logic [3:0] addr, input logic [31:0] data, input string tag);
      int n = 0;
      while (triggerOutRB !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rb_seen"}, {31'h0, triggerOutRB}, 32'd1);
      chk({tag, "_addr"}, {28'h0, addrRB}, {28'h0, addr});
      chk({tag, "_rw"}, {31'h0, rwRB}, 32'd0);
      readyInRB = 1'b1;
      dataInRB  = data;
      @(negedge clk);
      readyInRB = 1'b0;
      dataInRB  = '0;
      chk({tag, "_rb_width"}, {31'h0, triggerOutRB}, 32'd0);
   endtask

   task automatic expect_emit(input logic [3:0] typ, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] d3, input logic [31:0] d4, input string tag);
      int n = 0;
      while (triggerOut !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_trig"}, {31'h0, triggerOut}, 32'd1);
      chk({tag, "_type"}, {28'h0, typeOut}, {28'h0, typ});
      chk({tag, "_d1"}, dataOut1, d1);
      chk({tag, "_d2"}, dataOut2, d2);
      chk({tag, "_d3"}, dataOut3, d3);
      chk({tag, "_d4"}, dataOut4, d4);
      @(negedge clk);
      chk({tag, "_trig_width"}, {31'h0, triggerOut}, 32'd0);
      chk({tag, "_ready_after"}, {31'h0, readyOut}, 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {31'h0, readyOut}, 32'd0);
      chk({tag, "_trig"}, {31'h0, triggerOut}, 32'd0);
      chk({tag, "_trig_rb"}, {31'h0, triggerOutRB}, 32'd0);
      chk({tag, "_addr_rb"}, {28'h0, addrRB}, 32'd0);
      chk({tag, "_rw"}, {31'h0, rwRB}, 32'd0);
      chk({tag, "_type"}, {28'h0, typeOut}, 32'd0);
      chk({tag, "_d1"}, dataOut1, 32'd0);
      chk({tag, "_d2"}, dataOut2, 32'd0);
      chk({tag, "_d3"}, dataOut3, 32'd0);
      chk({tag, "_d4"}, dataOut4, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      dataIn    = '0;
      triggerIn = 1'b0;
      readyIn   = 1'b1;
      readyInRB = 1'b0;
      dataInRB  = '0;
      semRB     = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      chk("ready_before_edge", {31'h0, readyOut}, 32'd0);
      @(negedge clk);
      chk("ready_after_edge", {31'h0, readyOut}, 32'd1);

      // ADD r1,r2,r3
      base = rb_pulses;
      issue(32'hE0821003, "add");
      serve(4'd2, 32'h10, "add_rn");
      serve(4'd3, 32'h20, "add_rm");
      expect_emit(4'd0, 32'hE0821003, 32'h10, 32'h20, 32'h0, "add");
      chk("add_rb_count", rb_pulses - base, 32'd2);

      // MOV r0,#0xFF000000
      issue(32'hE3A004FF, "mov");
      serve(4'd0, 32'h5, "mov_rn");
      expect_emit(4'd1, 32'hE3A004FF, 32'h5, 32'hFF000000, 32'h0, "mov");

      // B .
      base = rb_pulses;
      issue(32'hEAFFFFFE, "b");
      expect_emit(4'd6, 32'hEAFFFFFE, 32'hFFFFFFF8, 32'h0, 32'h0, "b");
      chk("b_rb_count", rb_pulses - base, 32'd0);

      // STR r1,[r2,#4]
      issue(32'hE5821004, "str");
      serve(4'd2, 32'h100, "str_rn");
      serve(4'd1, 32'hAB, "str_rd");
      expect_emit(4'd4, 32'hE5821004, 32'h100, 32'h4, 32'hAB, "str");

      // MLA r3,r2,r1,r4
      issue(32'hE0234192, "mla");
      serve(4'd2, 32'h11, "mla_rm");
      serve(4'd1, 32'h22, "mla_rs");
      serve(4'd4, 32'h33, "mla_rn");
      expect_emit(4'd2, 32'hE0234192, 32'h11, 32'h22, 32'h33, "mla");

      // SWI 0xABCD
      base = rb_pulses;
      issue(32'hEF00ABCD, "swi");
      expect_emit(4'd7, 32'hEF00ABCD, 32'h0000ABCD, 32'h0, 32'h0, "swi");
      chk("swi_rb_count", rb_pulses - base, 32'd0);

      // BX lr
      issue(32'hE12FFF1E, "bx");
      serve(4'd14, 32'hDEAD, "bx_rm");
      expect_emit(4'd3, 32'hE12FFF1E, 32'hDEAD, 32'h0, 32'h0, "bx");

      // Register bank busy: no request until semRB drops
      semRB = 1'b1;
      issue(32'hE0821003, "sem");
      for (int i = 0; i < 10; i++) begin
         chk("sem_stall", {31'h0, triggerOutRB}, 32'd0);
         @(negedge clk);
      end
      semRB = 1'b0;
      @(negedge clk);
      chk("sem_first_pulse", {31'h0, triggerOutRB}, 32'd1);
      serve(4'd2, 32'h1, "sem_rn");
      serve(4'd3, 32'h2, "sem_rm");
      expect_emit(4'd0, 32'hE0821003, 32'h1, 32'h2, 32'h0, "sem");

      // Execute back-pressure, then reset aborts the held instruction
      readyIn = 1'b0;
      issue(32'hE0821003, "hold");
      serve(4'd2, 32'h7, "hold_rn");
      serve(4'd3, 32'h8, "hold_rm");
      for (int i = 0; i < 5; i++) begin
         chk("hold_trig", {31'h0, triggerOut}, 32'd0);
         chk("hold_ready", {31'h0, readyOut}, 32'd0);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      chk_all_zero("abort");
      @(negedge clk);
      rst     = 1'b0;
      readyIn = 1'b1;
      chk("abort_ready_before_edge", {31'h0, readyOut}, 32'd0);
      @(negedge clk);
      chk("abort_ready_after_edge", {31'h0, readyOut}, 32'd1);
      base = rb_pulses;
      for (int i = 0; i < 5; i++) begin
         chk("abort_no_trig", {31'h0, triggerOut}, 32'd0);
         @(negedge clk);
      end
      chk("abort_rb_count", rb_pulses - base, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
